// File: rtl/inv_sbox_serial.sv
// inv_sbox_serial
//   Serial AES inverse S-box over GF(2^8), reduction polynomial 0x11B.
//   The multiplicative inverse is formed as x^254 with one shared
//   combinational multiplier that performs one multiply per clock:
//   six square/multiply pairs build x^127, and a final square gives x^254.
//   A result appears 13 clock edges after the accepting edge and is held
//   until the consumer takes it.
//
// Ports
//   clk       rising-edge clock for all state
//   rst_n     synchronous active-low reset
//   fwd       (INV_SBOX_FWD_EN only) 1 = forward S-box for this operation,
//             sampled on the accepting edge
//   in_valid  in_data is valid this cycle
//   in_ready  block accepts input (high only in IDLE)
//   in_data   byte to substitute
//   out_valid out_data holds a finished result
//   out_ready consumer accepts out_data
//   out_data  substituted byte, registered
//   busy      high while computing or holding a result
//
// Configuration
//   INV_SBOX_FWD_EN  when defined, adds the fwd port and the forward S-box
//                    mode. Undefined: inverse S-box only, no fwd port.

module inv_sbox_serial (
  input  logic       clk,
  input  logic       rst_n,
`ifdef INV_SBOX_FWD_EN
  input  logic       fwd,
`endif
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Number of square/multiply pairs before the closing square.
  localparam logic [2:0] LAST_K = 3'd6;

  state_t     state;
  state_t     state_next;

  logic [7:0] x;       // affine-corrected operand, constant during an operation
  logic [7:0] r;       // running power of x
  logic [2:0] k;       // completed square/multiply pairs
  logic [7:0] mul_b;
  logic [7:0] prod;
  logic [7:0] load_val;
  logic [7:0] result;
  logic       accept;
  logic       finish;

`ifdef INV_SBOX_FWD_EN
  logic       fwd_q;
`endif

  // GF(2^8) multiply, shift-and-add with reduction by 0x11B.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
    end
    return acc;
  endfunction

  // Inverse AES affine: b[i] = a[i+2] ^ a[i+5] ^ a[i+7] ^ c[i], c = 0x05.
  function automatic logic [7:0] inv_affine(input logic [7:0] a);
    logic [7:0] b;
    logic [7:0] c;
    c = 8'h05;
    b = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      b[i] = a[(i + 2) % 8] ^ a[(i + 5) % 8] ^ a[(i + 7) % 8] ^ c[i];
    end
    return b;
  endfunction

`ifdef INV_SBOX_FWD_EN
  // Forward AES affine: b[i] = a[i] ^ a[i+4] ^ a[i+5] ^ a[i+6] ^ a[i+7] ^ c[i], c = 0x63.
  function automatic logic [7:0] fwd_affine(input logic [7:0] a);
    logic [7:0] b;
    logic [7:0] c;
    c = 8'h63;
    b = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      b[i] = a[i] ^ a[(i + 4) % 8] ^ a[(i + 5) % 8] ^ a[(i + 6) % 8]
           ^ a[(i + 7) % 8] ^ c[i];
    end
    return b;
  endfunction
`endif

  // Shared multiplier: squares r in SQR, multiplies r by x in MUL.
  always_comb begin
    mul_b = (state == MUL) ? x : r;
    prod  = gf_mul(r, mul_b);
  end

  // Load value and registered result, with optional forward mode.
  always_comb begin
`ifdef INV_SBOX_FWD_EN
    load_val = fwd ? in_data : inv_affine(in_data);
    result   = fwd_q ? fwd_affine(prod) : prod;
`else
    load_val = inv_affine(in_data);
    result   = prod;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    accept     = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = SQR;
        end
      end
      SQR: begin
        if (k == LAST_K) begin
          finish     = 1'b1;
          state_next = DONE;
        end else begin
          state_next = MUL;
        end
      end
      MUL: begin
        state_next = SQR;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers. out_data is written only on the edge entering DONE,
  // so it stays stable while a result is held and between operations.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x        <= '0;
      r        <= '0;
      k        <= '0;
      out_data <= '0;
`ifdef INV_SBOX_FWD_EN
      fwd_q    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        x <= load_val;
        r <= load_val;
        k <= '0;
`ifdef INV_SBOX_FWD_EN
        fwd_q <= fwd;
`endif
      end else if (state == SQR) begin
        r <= prod;
        if (finish) out_data <= result;
      end else if (state == MUL) begin
        r <= prod;
        k <= k + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_inv_sbox_serial.sv
module tb_inv_sbox_serial;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
`ifdef INV_SBOX_FWD_EN
  logic       fwd;
`endif

  int n_cmp;
  int n_fail;

  logic [7:0] golden_inv [256];

  inv_sbox_serial dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef INV_SBOX_FWD_EN
    .fwd      (fwd),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Carry-less product followed by polynomial reduction by 0x11B.
  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11B << (i - 8));
    return p[7:0];
  endfunction

  // Forward S-box by brute-force inversion, then invert the table.
  task automatic build_golden();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (tb_mul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
             ^ inv[(i + 7) % 8] ^ c[i];
      golden_inv[s] = 8'(v);
    end
  endtask

  // One transaction: wait for ready, present din, count edges to out_valid,
  // capture the result, hold out_ready low for 'hold' cycles, then take it.
  task automatic run_one(input logic [7:0] din, input int hold,
                         output logic [7:0] dout, output int lat);
    int w;
    dout = 8'hxx;
    lat  = 0;
    w    = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) return;
    in_valid = 1'b1;
    in_data  = din;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) return;
    dout = out_data;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++;
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", out_data); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_vectors();
    logic [7:0] vin  [6];
    logic [7:0] vexp [6];
    logic [7:0] d;
    int lat;
    vin  = '{8'h63, 8'h7C, 8'h00, 8'h01, 8'hED, 8'h16};
    vexp = '{8'h00, 8'h01, 8'h52, 8'h09, 8'h53, 8'hFF};
    for (int i = 0; i < 6; i++) begin
      run_one(vin[i], 0, d, lat);
      n_cmp++;
      if (d !== vexp[i]) begin
        n_fail++; $display("FAIL vec_data in=%h got %h want %h", vin[i], d, vexp[i]);
      end
      n_cmp++;
      if (lat !== 13) begin
        n_fail++; $display("FAIL vec_latency in=%h got %0d want 13", vin[i], lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int w;
    in_valid = 1'b1;
    in_data  = 8'h01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 40) begin
      @(posedge clk); #1; w++;
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_wait got out_valid %b want 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 8'hAA;
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'h09 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d got valid=%b data=%h ready=%b want valid=1 data=09 ready=0",
                 i, out_valid, out_data, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release got valid=%b ready=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
    n_cmp++;
    if (out_data !== 8'h09) begin n_fail++; $display("FAIL bp_data_kept got %h want 09", out_data); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_ignored_pulse got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    int lat;
    in_valid = 1'b1;
    in_data  = 8'hED;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before got %b want 1", busy); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset got valid=%b busy=%b ready=%b want 0 0 1", out_valid, busy, in_ready);
    end
    n_cmp++;
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL mid_reset_data got %h want 00", out_data); end
    run_one(8'h01, 0, d, lat);
    n_cmp++;
    if (d !== 8'h09 || lat !== 13) begin
      n_fail++; $display("FAIL mid_after got data=%h lat=%0d want 09 13", d, lat);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] d;
    int lat;
    for (int v = 0; v < 256; v++) begin
      run_one(8'(v), int'($urandom_range(0, 3)), d, lat);
      n_cmp++;
      if (d !== golden_inv[v] || lat !== 13) begin
        n_fail++;
        $display("FAIL sweep in=%h got data=%h lat=%0d want %h 13", v[7:0], d, lat, golden_inv[v]);
      end
    end
  endtask

`ifdef INV_SBOX_FWD_EN
  task automatic test_fwd();
    logic [7:0] vin  [3];
    logic [7:0] vexp [3];
    logic [7:0] d;
    int lat;
    vin  = '{8'h00, 8'h01, 8'h53};
    vexp = '{8'h63, 8'h7C, 8'hED};
    for (int i = 0; i < 3; i++) begin
      fwd = 1'b1;
      run_one(vin[i], 0, d, lat);
      fwd = 1'b0;
      n_cmp++;
      if (d !== vexp[i] || lat !== 13) begin
        n_fail++; $display("FAIL fwd in=%h got data=%h lat=%0d want %h 13", vin[i], d, lat, vexp[i]);
      end
    end
  endtask
`endif

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
`ifdef INV_SBOX_FWD_EN
    fwd       = 1'b0;
`endif
    build_golden();
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_sweep();
`ifdef INV_SBOX_FWD_EN
    test_fwd();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_sbox_serial.md
INV_SBOX_SERIAL -- requirements
Module: inv_sbox_serial

Interface
REQ-001 No parameters; the design is fixed to the AES field GF(2^8) with reduction polynomial 0x11B.
REQ-002 One clock; reset is synchronous and active-low. Ports clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_ready  output  1  block accepts input; high only in IDLE.
REQ-007 in_data  input  8  byte to substitute.
REQ-008 out_valid  output  1  out_data holds a finished result.
REQ-009 out_ready  input  1  consumer accepts out_data.
REQ-010 out_data  output  8  substituted byte, registered.
REQ-011 busy  output  1  high in SQR, MUL or DONE.

Function
REQ-012 Result SHALL be the AES inverse S-box: out = inv(InvAffine(in)), with inv(0) = 0.
REQ-013 InvAffine bit i SHALL be a[(i+2)%8] ^ a[(i+5)%8] ^ a[(i+7)%8] ^ c[i], where c = 0x05.
REQ-014 inv(x) SHALL be computed as x^254 using one shared combinational GF(2^8) multiplier, exactly one multiply per cycle.
REQ-015 FSM states SHALL be IDLE, SQR, MUL and DONE.
REQ-016 On the edge where in_valid && in_ready, the block SHALL load x = r = InvAffine(in_data), clear step counter k, and move IDLE->SQR.
REQ-017 SQR SHALL set r = r*r. If k < 6, go to MUL; if k == 6, go to DONE and register out_data.
REQ-018 MUL SHALL set r = r*x, increment k, and go to SQR.
REQ-019 The sequence SHALL be 13 multiplies: x^3, x^7, ..., x^127, then a final square giving x^254.
REQ-020 out_valid SHALL rise exactly 13 clock edges after the accepting edge.
REQ-021 DONE SHALL hold out_valid and a stable out_data until out_ready is sampled high, then return to IDLE (out_valid low on the next cycle).
REQ-022 in_valid SHALL be ignored outside IDLE. No input is accepted in the cycle DONE exits, so the minimum spacing between accepts is 15 cycles.
REQ-023 out_data SHALL change only on the edge entering DONE.

Reset
REQ-024 When rst_n = 0 at a rising edge, the block SHALL go to IDLE with out_valid = 0, busy = 0, out_data = 0x00, x = r = 0x00, k = 0.
REQ-025 After reset, in_ready SHALL be 1.
REQ-026 Reset mid-operation SHALL abort the computation with no partial output; the next accepted byte SHALL compute correctly.

Configuration
REQ-027 Macro INV_SBOX_FWD_EN, when defined, SHALL add input port fwd (1 bit), sampled only at the accepting edge and held internally for that operation.
REQ-028 With the macro defined and fwd = 1:
- the load SHALL skip InvAffine (x = r = in_data);
- the forward AES affine (constant 0x63) SHALL be applied when registering out_data;
- the result is the forward S-box, with identical latency and handshake.
REQ-029 With the macro defined and fwd = 0, or with the macro undefined, behaviour SHALL be inverse-only. Without the macro the fwd port SHALL NOT exist.

Verification
REQ-030 Reset, then in_data = 0x63 -> out_data = 0x00, 13 edges after accept.
REQ-031 Inputs 0x7C, 0x00, 0x01, 0xED, 0x16 -> outputs 0x01, 0x52, 0x09, 0x53, 0xFF respectively.
REQ-032 Hold out_ready = 0 for 5 cycles after out_valid -> out_valid and out_data stay stable, in_ready stays 0, and in_valid pulses are ignored.
REQ-033 Assert rst_n = 0 at the 6th compute cycle -> next cycle out_valid = 0, busy = 0, in_ready = 1. A subsequent input 0x01 -> output 0x09.
REQ-034 Exhaustive sweep of all 256 inputs against a golden inverse S-box table, with out_ready randomly throttled -> all results match.
REQ-035 With INV_SBOX_FWD_EN defined and fwd = 1: inputs 0x00, 0x01, 0x53 -> outputs 0x63, 0x7C, 0xED.
